// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Optional per-neuron saturating spike counters are enabled with `define LIF_SPIKE_COUNT_EN.
module lif_neuron_array #(
  parameter int WIDTH      = 16,
  parameter int N_NEURONS  = 8,
  parameter int REFR_W     = 8,
  parameter int RST_THRESH = 10000,
  parameter int RST_LEAK   = 0,
  parameter int RST_REFR   = 5,
  parameter int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_start,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in_current,
  output logic [IDX_W-1:0]         cur_idx,
  input  logic                     load_params,
  input  logic signed [WIDTH-1:0]  new_V_threshold,
  input  logic [WIDTH-1:0]         new_leak_factor,
  input  logic [REFR_W-1:0]        new_refr_period,
  input  logic signed [WIDTH-1:0]  new_V_max,
  input  logic signed [WIDTH-1:0]  new_V_min,
  output logic                     param_err,
  output logic [N_NEURONS-1:0]     spike_vec,
  output logic                     step_done,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [15:0]              rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]  v_mem [N_NEURONS];
  logic [REFR_W-1:0]        r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]     spike_acc;

  logic signed [WIDTH-1:0]  v_threshold;
  logic [WIDTH-1:0]         leak_factor;
  logic [REFR_W-1:0]        refr_period;
  logic signed [WIDTH-1:0]  v_max;
  logic signed [WIDTH-1:0]  v_min;

  logic signed [WIDTH-1:0]  v_cur;
  logic [REFR_W-1:0]        r_cur;
  logic signed [2*WIDTH:0]  v_ext;
  logic signed [2*WIDTH:0]  lf_ext;
  logic signed [2*WIDTH:0]  prod;
  logic signed [WIDTH+1:0]  leak_amt;
  logic signed [WIDTH+1:0]  v_wide;
  logic signed [WIDTH+1:0]  i_wide;
  logic signed [WIDTH+1:0]  sum;
  logic signed [WIDTH+1:0]  vmax_wide;
  logic signed [WIDTH+1:0]  vmin_wide;
  logic signed [WIDTH-1:0]  v_sat;
  logic                     handshake;
  logic                     refractory;
  logic                     fire;
  logic                     spike_now;
  logic                     last_idx;
  logic [N_NEURONS-1:0]     spike_bit;
  logic                     prod_unused;

  assign v_cur      = v_mem[cur_idx];
  assign r_cur      = r_mem[cur_idx];
  assign handshake  = in_valid && in_ready;
  assign refractory = (r_cur != '0);
  assign last_idx   = (cur_idx == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    in_ready   = 1'b0;
    step_done  = 1'b0;
    case (state)
      IDLE: begin
        if (step_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (handshake && last_idx) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        step_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Leak is a floor of V*leak/2^WIDTH; the sum is kept two bits wider so clamping sees the true value.
  always_comb begin
    v_ext       = {{(WIDTH+1){v_cur[WIDTH-1]}}, v_cur};
    lf_ext      = {{(WIDTH+1){1'b0}}, leak_factor};
    prod        = v_ext * lf_ext;
    leak_amt    = {prod[2*WIDTH], prod[2*WIDTH:WIDTH]};
    prod_unused = ^prod[WIDTH-1:0];
    v_wide      = {{2{v_cur[WIDTH-1]}}, v_cur};
    i_wide      = {{2{in_current[WIDTH-1]}}, in_current};
    vmax_wide   = {{2{v_max[WIDTH-1]}}, v_max};
    vmin_wide   = {{2{v_min[WIDTH-1]}}, v_min};
    sum         = v_wide - leak_amt + i_wide;
    if (sum > vmax_wide) begin
      v_sat = v_max;
    end else if (sum < vmin_wide) begin
      v_sat = v_min;
    end else begin
      v_sat = sum[WIDTH-1:0];
    end
    fire      = (v_sat >= v_threshold);
    spike_now = handshake && !refractory && fire;
    spike_bit = '0;
    spike_bit[cur_idx] = spike_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx     <= '0;
      spike_acc   <= '0;
      spike_vec   <= '0;
      param_err   <= 1'b0;
      v_threshold <= WIDTH'(RST_THRESH);
      leak_factor <= WIDTH'(RST_LEAK);
      refr_period <= REFR_W'(RST_REFR);
      v_max       <= {1'b0, {(WIDTH-1){1'b1}}};
      v_min       <= {1'b1, {(WIDTH-1){1'b0}}};
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      param_err <= load_params && (state != IDLE);

      if ((state == IDLE) && load_params) begin
        v_threshold <= new_V_threshold;
        leak_factor <= new_leak_factor;
        refr_period <= new_refr_period;
        v_max       <= new_V_max;
        v_min       <= new_V_min;
      end

      if ((state == IDLE) && step_start) begin
        cur_idx   <= '0;
        spike_acc <= '0;
      end

      if (handshake) begin
        if (refractory) begin
          v_mem[cur_idx] <= '0;
          r_mem[cur_idx] <= r_cur - REFR_W'(1);
        end else if (fire) begin
          v_mem[cur_idx] <= '0;
          r_mem[cur_idx] <= refr_period;
        end else begin
          v_mem[cur_idx] <= v_sat;
        end
        spike_acc <= spike_acc | spike_bit;
        // The last neuron's spike is folded in here so spike_vec is valid during the step_done cycle.
        if (last_idx) begin
          spike_vec <= spike_acc | spike_bit;
          cur_idx   <= '0;
        end else begin
          cur_idx <= cur_idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] spike_cnt [N_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        spike_cnt[i] <= '0;
      end
    end else if (spike_now && (spike_cnt[cur_idx] != 16'hFFFF)) begin
      spike_cnt[cur_idx] <= spike_cnt[cur_idx] + 16'd1;
    end
  end

  assign rd_count = spike_cnt[rd_idx];
`else
  logic rd_idx_unused;

  assign rd_idx_unused = ^rd_idx;
  assign rd_count      = '0;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array with four neurons.
// Expected membrane values are hand-computed from the leak/clamp/threshold rules.
module tb_lif_neuron_array;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int REFRW = 8;
  localparam int IDXW  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    step_start;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_current;
  logic [IDXW-1:0]         cur_idx;
  logic                    load_params;
  logic signed [WIDTH-1:0] new_V_threshold;
  logic [WIDTH-1:0]        new_leak_factor;
  logic [REFRW-1:0]        new_refr_period;
  logic signed [WIDTH-1:0] new_V_max;
  logic signed [WIDTH-1:0] new_V_min;
  logic                    param_err;
  logic [N-1:0]            spike_vec;
  logic                    step_done;
  logic [IDXW-1:0]         rd_idx;
  logic [15:0]             rd_count;

  int checks;
  int failures;
  int cyc;
  int seen_done;

  lif_neuron_array #(
    .WIDTH     (WIDTH),
    .N_NEURONS (N),
    .REFR_W    (REFRW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .step_start      (step_start),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_current      (in_current),
    .cur_idx         (cur_idx),
    .load_params     (load_params),
    .new_V_threshold (new_V_threshold),
    .new_leak_factor (new_leak_factor),
    .new_refr_period (new_refr_period),
    .new_V_max       (new_V_max),
    .new_V_min       (new_V_min),
    .param_err       (param_err),
    .spike_vec       (spike_vec),
    .step_done       (step_done),
    .rd_idx          (rd_idx),
    .rd_count        (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
      $error("[TB] check %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkV(input string tag, input int k, input int expected);
    checkOutput(tag, 32'($signed(dut.v_mem[k])), 32'(expected));
  endtask

  task automatic loadParams(input int thresh, input int leak, input int refr, input int vmax, input int vmin);
    @(negedge clk);
    new_V_threshold = 16'(thresh);
    new_leak_factor = 16'(leak);
    new_refr_period = 8'(refr);
    new_V_max       = 16'(vmax);
    new_V_min       = 16'(vmin);
    load_params     = 1'b1;
    @(negedge clk);
    load_params     = 1'b0;
  endtask

  // Runs one full timestep with in_valid held high; returns at the negedge where step_done is seen.
  task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3, output int cycles);
    int cur [4];
    cur = '{c0, c1, c2, c3};
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    cycles = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid   = 1'b1;
      in_current = 16'(cur[k]);
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    while (step_done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    step_start      = 1'b0;
    in_valid        = 1'b0;
    in_current      = '0;
    load_params     = 1'b0;
    new_V_threshold = '0;
    new_leak_factor = '0;
    new_refr_period = '0;
    new_V_max       = '0;
    new_V_min       = '0;
    rd_idx          = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
    checkOutput("rst_step_done", 32'(step_done), 32'(0));
    checkOutput("rst_param_err", 32'(param_err), 32'(0));
    checkOutput("rst_cur_idx", 32'(cur_idx), 32'(0));
    checkOutput("rst_spike_vec", 32'(spike_vec), 32'(0));
    checkOutput("rst_thresh", 32'($signed(dut.v_threshold)), 32'(10000));
    checkOutput("rst_vmax", 32'($signed(dut.v_max)), 32'(32767));
    checkOutput("rst_vmin", 32'($signed(dut.v_min)), 32'(-32768));
    checkOutput("rst_refr", 32'(dut.refr_period), 32'(5));
    checkV("rst_v0", 0, 0);

    $display("[TB] basic integrate and fire");
    loadParams(10000, 0, 2, 30000, -30000);
    applyStimulus(6000, 11000, -32768, 0, cyc);
    checkOutput("s1_cycles", 32'(cyc), 32'(5));
    checkOutput("s1_spikes", 32'(spike_vec), 32'(4'b0010));
    checkV("s1_v0", 0, 6000);
    checkV("s1_v1", 1, 0);
    checkV("s1_v2", 2, -30000);
    checkV("s1_v3", 3, 0);
    @(negedge clk);
    checkOutput("s1_done_pulse", 32'(step_done), 32'(0));
    checkOutput("s1_idle_busy", 32'(busy), 32'(0));
    checkOutput("s1_spike_hold", 32'(spike_vec), 32'(4'b0010));

    $display("[TB] refractory behaviour");
    applyStimulus(6000, 20000, 0, 0, cyc);
    checkOutput("s2_spikes", 32'(spike_vec), 32'(4'b0001));
    checkV("s2_v1", 1, 0);
    checkV("s2_v0", 0, 0);
    applyStimulus(0, 20000, 0, 0, cyc);
    checkOutput("s3_spikes", 32'(spike_vec), 32'(4'b0000));
    applyStimulus(0, 20000, 0, 0, cyc);
    checkOutput("s4_spikes", 32'(spike_vec), 32'(4'b0010));

    $display("[TB] leak with floor shift");
    loadParams(30000, 3277, 2, 30000, -30000);
    applyStimulus(20000, 0, 0, -20000, cyc);
    checkOutput("l1_spikes", 32'(spike_vec), 32'(0));
    checkV("l1_v0", 0, 20000);
    checkV("l1_v2", 2, -28499);
    checkV("l1_v3", 3, -20000);
    applyStimulus(0, 0, 0, 0, cyc);
    checkV("l2_v0_pos_leak", 0, 19000);
    checkV("l2_v3_neg_leak", 3, -18999);
    checkV("l2_v2", 2, -27073);

    $display("[TB] saturation and threshold boundary");
    loadParams(30000, 0, 2, 20000, -30000);
    applyStimulus(-4000, 0, 0, 0, cyc);
    checkV("o1_v0", 0, 15000);
    applyStimulus(32767, 0, 0, -32768, cyc);
    checkOutput("o2_spikes", 32'(spike_vec), 32'(0));
    checkV("o2_v0_clamp_hi", 0, 20000);
    checkV("o2_v3_clamp_lo", 3, -30000);
    loadParams(20000, 0, 2, 20000, -30000);
    applyStimulus(0, 0, 0, 0, cyc);
    checkOutput("o3_spikes_eq", 32'(spike_vec), 32'(4'b0001));
    checkV("o3_v0", 0, 0);

    $display("[TB] stall, param error, ignored start");
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    in_valid   = 1'b1;
    in_current = 16'sd100;
    @(negedge clk);
    checkOutput("st_idx1", 32'(cur_idx), 32'(1));
    in_valid        = 1'b0;
    in_current      = 16'sd5000;
    new_V_threshold = 16'sd1;
    load_params     = 1'b1;
    step_start      = 1'b1;
    @(negedge clk);
    load_params = 1'b0;
    step_start  = 1'b0;
    checkOutput("st_param_err", 32'(param_err), 32'(1));
    checkOutput("st_idx_hold", 32'(cur_idx), 32'(1));
    checkOutput("st_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    checkOutput("st_param_err_pulse", 32'(param_err), 32'(0));
    @(negedge clk);
    checkOutput("st_idx_hold3", 32'(cur_idx), 32'(1));
    checkOutput("st_busy", 32'(busy), 32'(1));
    checkV("st_v1_unchanged", 1, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_current = 16'sd0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("st_step_done", 32'(step_done), 32'(1));
    checkOutput("st_spikes", 32'(spike_vec), 32'(0));
    checkV("st_v1", 1, 5000);
    checkOutput("st_thresh_kept", 32'($signed(dut.v_threshold)), 32'(20000));
    @(negedge clk);
    checkOutput("st_idle", 32'(busy), 32'(0));

    $display("[TB] reset mid-step");
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    in_valid   = 1'b1;
    in_current = 16'sd100;
    @(negedge clk);
    in_current = 16'sd1000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("mr_busy", 32'(busy), 32'(0));
    checkOutput("mr_in_ready", 32'(in_ready), 32'(0));
    checkV("mr_v1", 1, 0);
    checkV("mr_v2", 2, 0);
    checkOutput("mr_spikes", 32'(spike_vec), 32'(0));
    checkOutput("mr_thresh", 32'($signed(dut.v_threshold)), 32'(10000));
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (step_done === 1'b1) seen_done = 1;
    end
    checkOutput("mr_no_done", 32'(seen_done), 32'(0));
    checkOutput("mr_cur_idx", 32'(cur_idx), 32'(0));

    $display("[TB] spike counter read");
    loadParams(10000, 0, 0, 32767, -32768);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(32767, 0, 0, 0, cyc);
      checkOutput("sc_spikes", 32'(spike_vec), 32'(4'b0001));
    end
    checkV("sc_v0_refr0", 0, 0);
    rd_idx = 2'd0;
    #1;
`ifdef LIF_SPIKE_COUNT_EN
    checkOutput("sc_count0", 32'(rd_count), 32'(3));
`else
    checkOutput("sc_count0", 32'(rd_count), 32'(0));
`endif
    rd_idx = 2'd1;
    #1;
    checkOutput("sc_count1", 32'(rd_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
